// File: rtl/adder_pkg.sv
// Shared definitions for the digit-serial adder/subtractor.
package adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/digit_serial_addsub_if.sv
// Start/busy/done operand and result bundle for digit_serial_addsub.
interface digit_serial_addsub_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    modport master (output start, a, b, cin, sub, input busy, done, s, cout, ovf);
    modport slave  (input start, a, b, cin, sub, output busy, done, s, cout, ovf);
endinterface

// File: rtl/digit_adder.sv
// Combinational W-bit ripple adder built from per-bit sum/carry functions.
module digit_adder #(
    parameter int W = 4
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         ci,
    output logic [W-1:0] sum,
    output logic         co
);

    function automatic logic sum_bit(input logic p, input logic q, input logic c);
        return p ^ q ^ c;
    endfunction

    function automatic logic carry_bit(input logic p, input logic q, input logic c);
        return (p & q) | (c & (p ^ q));
    endfunction

    always_comb begin
        logic c;
        c   = ci;
        sum = '0;
        for (int i = 0; i < W; i++) begin
            sum[i] = sum_bit(x[i], y[i], c);
            c      = carry_bit(x[i], y[i], c);
        end
        co = c;
    end

endmodule

// File: rtl/digit_serial_addsub.sv
// Multi-cycle adder/subtractor: DIGIT bits per clock, carry held between digits.
module digit_serial_addsub
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    digit_serial_addsub_if.slave bus
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_check
        $error("digit_serial_addsub: WIDTH must be a multiple of DIGIT, 1 <= DIGIT <= WIDTH");
    end

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_s;
    logic             r_cout;
    logic             r_ovf;

    logic [DIGIT-1:0] w_sum;
    logic             w_co;
    logic [WIDTH-1:0] w_res_next;

    digit_adder #(.W(DIGIT)) u_digit_adder (
        .x   (r_a[DIGIT-1:0]),
        .y   (r_b[DIGIT-1:0]),
        .ci  (r_carry),
        .sum (w_sum),
        .co  (w_co)
    );

    // New digit enters at the top; after NDIG shifts the first digit sits at the LSB.
    assign w_res_next = WIDTH'({w_sum, r_res} >> DIGIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_a     <= bus.a;
                        r_b     <= bus.sub ? ~bus.b : bus.b;
                        r_carry <= bus.sub | bus.cin;
                        r_cnt   <= '0;
                        r_a_msb <= bus.a[WIDTH-1];
                        r_b_msb <= bus.sub ? ~bus.b[WIDTH-1] : bus.b[WIDTH-1];
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_res   <= w_res_next;
                    r_carry <= w_co;
                    if (r_cnt == CW'(NDIG - 1)) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_s     <= w_res_next;
                        r_cout  <= w_co;
                        r_ovf   <= (r_a_msb == r_b_msb) && (w_res_next[WIDTH-1] != r_a_msb);
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.s    = r_s;
    assign bus.cout = r_cout;
    assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Bench for digit_serial_addsub: 16/4 main instance plus 8/1 and 8/8 sweep instances.
module tb_digit_serial_addsub;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    digit_serial_addsub_if #(.WIDTH(16)) m_if ();
    digit_serial_addsub_if #(.WIDTH(8))  p1_if ();
    digit_serial_addsub_if #(.WIDTH(8))  p8_if ();

    digit_serial_addsub #(.WIDTH(16), .DIGIT(4)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(m_if));
    digit_serial_addsub #(.WIDTH(8),  .DIGIT(1)) u_dut8_1 (.clk(clk), .rst_n(rst_n), .bus(p1_if));
    digit_serial_addsub #(.WIDTH(8),  .DIGIT(8)) u_dut8_8 (.clk(clk), .rst_n(rst_n), .bus(p8_if));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        bit          cin;
        bit          sub;
        logic [15:0] s;
        bit          cout;
        bit          ovf;
    } vec_t;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: integer sum / difference, signed overflow as an out-of-range check.
    function automatic void model(input int w, input longint a, input longint b,
                                  input bit ci, input bit sb,
                                  output longint s, output bit co, output bit ov);
        longint m, tot, sa, sbv, r;
        m   = longint'(1) << w;
        tot = sb ? (a + (m - b)) : (a + b + longint'(ci));
        s   = tot % m;
        co  = (tot >= m);
        sa  = (a >= m / 2) ? a - m : a;
        sbv = (b >= m / 2) ? b - m : b;
        r   = sb ? (sa - sbv) : (sa + sbv + longint'(ci));
        ov  = (r >= m / 2) || (r < -(m / 2));
    endfunction

    // Called at a falling edge; returns at the falling edge of the done cycle.
    task automatic do_op16(input logic [15:0] a, input logic [15:0] b, input bit ci, input bit sb,
                           input logic [15:0] es, input bit ec, input bit eo, input string nm);
        int cyc;
        int busy_cyc;
        m_if.start = 1'b1;
        m_if.a     = a;
        m_if.b     = b;
        m_if.cin   = ci;
        m_if.sub   = sb;
        @(negedge clk);
        m_if.start = 1'b0;
        m_if.a     = 16'($urandom);
        m_if.b     = 16'($urandom);
        m_if.cin   = ~ci;
        m_if.sub   = ~sb;
        cyc        = 1;
        busy_cyc   = 0;
        while (!m_if.done && cyc < 40) begin
            if (m_if.busy) busy_cyc++;
            @(negedge clk);
            cyc++;
        end
        chk({nm, " done_cycle"}, cyc, 5);
        chk({nm, " busy_cycles"}, busy_cyc, 4);
        chk({nm, " busy_at_done"}, m_if.busy, 0);
        chk({nm, " s"}, m_if.s, es);
        chk({nm, " cout"}, m_if.cout, ec);
        chk({nm, " ovf"}, m_if.ovf, eo);
    endtask

    // Drives both 8-bit instances with one operation and checks each one's latency and result.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit ci, input bit sb,
                       input logic [7:0] es, input bit ec, input bit eo, input string nm);
        int d1, d8;
        logic [7:0] s1, s8;
        bit c1, c8, o1, o8;
        d1 = 0; d8 = 0; s1 = '0; s8 = '0; c1 = 0; c8 = 0; o1 = 0; o8 = 0;
        p1_if.start = 1'b1; p1_if.a = a; p1_if.b = b; p1_if.cin = ci; p1_if.sub = sb;
        p8_if.start = 1'b1; p8_if.a = a; p8_if.b = b; p8_if.cin = ci; p8_if.sub = sb;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                p1_if.start = 1'b0; p1_if.a = 8'($urandom); p1_if.b = 8'($urandom);
                p8_if.start = 1'b0; p8_if.a = 8'($urandom); p8_if.b = 8'($urandom);
            end
            if (p1_if.done && d1 == 0) begin
                d1 = cyc; s1 = p1_if.s; c1 = p1_if.cout; o1 = p1_if.ovf;
            end
            if (p8_if.done && d8 == 0) begin
                d8 = cyc; s8 = p8_if.s; c8 = p8_if.cout; o8 = p8_if.ovf;
            end
        end
        chk({nm, " d1 done_cycle"}, d1, 9);
        chk({nm, " d1 s"}, s1, es);
        chk({nm, " d1 cout"}, c1, ec);
        chk({nm, " d1 ovf"}, o1, eo);
        chk({nm, " d8 done_cycle"}, d8, 2);
        chk({nm, " d8 s"}, s8, es);
        chk({nm, " d8 cout"}, c8, ec);
        chk({nm, " d8 ovf"}, o8, eo);
    endtask

    initial begin
        vec_t   vecs[$];
        longint es;
        bit     ec, eo;
        int     cyc, ndone, nbusy;
        logic [15:0] ra, rb;
        bit     rc, rs;

        n_chk = 0;
        n_err = 0;
        vecs.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0});
        vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
        vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1});
        vecs.push_back('{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0});
        vecs.push_back('{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1});
        vecs.push_back('{16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0});

        m_if.start  = 0; m_if.a  = '0; m_if.b  = '0; m_if.cin  = 0; m_if.sub  = 0;
        p1_if.start = 0; p1_if.a = '0; p1_if.b = '0; p1_if.cin = 0; p1_if.sub = 0;
        p8_if.start = 0; p8_if.a = '0; p8_if.b = '0; p8_if.cin = 0; p8_if.sub = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset busy", m_if.busy, 0);
        chk("reset done", m_if.done, 0);
        chk("reset s", m_if.s, 0);
        chk("reset cout", m_if.cout, 0);
        chk("reset ovf", m_if.ovf, 0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            do_op16(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                    vecs[i].s, vecs[i].cout, vecs[i].ovf, $sformatf("vec%0d", i));
            @(negedge clk);
            chk($sformatf("vec%0d done_pulse_len", i), m_if.done, 0);
        end

        // start held through RUN with changing operands must not disturb the first op
        m_if.start = 1'b1; m_if.a = 16'h1234; m_if.b = 16'h4321; m_if.cin = 0; m_if.sub = 0;
        @(negedge clk);
        cyc = 1;
        while (!m_if.done && cyc < 40) begin
            if (cyc <= 3) begin
                m_if.a = 16'($urandom);
                m_if.b = 16'($urandom);
            end else begin
                m_if.start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        m_if.start = 1'b0;
        chk("held_start done_cycle", cyc, 5);
        chk("held_start s", m_if.s, 16'h5555);
        @(negedge clk);
        chk("held_start no_requeue busy", m_if.busy, 0);
        chk("held_start no_requeue done", m_if.done, 0);

        // back-to-back: second start arrives in the DONE cycle
        do_op16(16'h1111, 16'h2222, 0, 0, 16'h3333, 0, 0, "b2b_first");
        do_op16(16'hABCD, 16'h1111, 0, 1, 16'h9ABC, 1, 0, "b2b_second");
        @(negedge clk);

        // asynchronous reset in RUN cycle 2
        m_if.start = 1'b1; m_if.a = 16'h4444; m_if.b = 16'h1111; m_if.cin = 0; m_if.sub = 0;
        @(negedge clk);
        m_if.start = 1'b0;
        chk("pre_reset busy", m_if.busy, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset busy", m_if.busy, 0);
        chk("async_reset done", m_if.done, 0);
        chk("async_reset s", m_if.s, 0);
        chk("async_reset cout", m_if.cout, 0);
        chk("async_reset ovf", m_if.ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        nbusy = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (m_if.done) ndone++;
            if (m_if.busy) nbusy++;
        end
        chk("post_reset done_pulses", ndone, 0);
        chk("post_reset busy_cycles", nbusy, 0);
        do_op16(16'h00FF, 16'h0001, 0, 0, 16'h0100, 0, 0, "after_reset");
        @(negedge clk);

        // parameter sweep instances
        op8(8'hA5, 8'h5B, 0, 0, 8'h00, 1, 0, "sweep_a5_5b");
        op8(8'h7F, 8'h01, 0, 0, 8'h80, 0, 1, "sweep_7f_01");
        op8(8'h03, 8'h05, 1, 1, 8'hFE, 0, 0, "sweep_sub");

        // randomized back-to-back operations against the model
        for (int k = 0; k < 1000; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            if (k % 10 == 0) rb = 16'hFFFF - ra;
            model(16, longint'(ra), longint'(rb), rc, rs, es, ec, eo);
            do_op16(ra, rb, rc, rs, 16'(es), ec, eo, $sformatf("rnd16_%0d", k));
        end
        @(negedge clk);
        for (int k = 0; k < 150; k++) begin
            ra = 16'($urandom_range(0, 255));
            rb = 16'($urandom_range(0, 255));
            rc = 1'($urandom);
            rs = 1'($urandom);
            model(8, longint'(ra), longint'(rb), rc, rs, es, ec, eo);
            op8(ra[7:0], rb[7:0], rc, rs, 8'(es), ec, eo, $sformatf("rnd8_%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
